// File: rtl/fpu_result_queue.sv
// fpu_result_queue
// Capture stage behind the combinational FPU adder. Each accepted result is
// stored with its tag and a one-hot class {nan,inf,zero,normal}. The head entry
// is presented on out_* with a valid/ready handshake. The block also keeps
// sticky exception flags {zero_seen,overflow,invalid} and a saturating count
// of popped results.
// in_ready depends only on occupancy, so it never has a combinational path
// from out_ready. A push is visible on out_* one edge later; there is no
// bypass around the storage.

module fpu_result_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_class,
    output logic [2:0]       flags,
    input  logic             flags_clr,
    output logic [CNT_W-1:0] res_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0] OCC_ONE = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Class bit positions in out_class and flag bit positions in flags.
    localparam int CLS_NORMAL = 0;
    localparam int CLS_ZERO   = 1;
    localparam int CLS_INF    = 2;
    localparam int CLS_NAN    = 3;
    localparam int FLG_INVALID  = 0;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_ZERO     = 2;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [31:0]      res_mem_q [DEPTH];
    logic [31:0]      res_mem_d [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_d [DEPTH];
    logic [3:0]       cls_mem_q [DEPTH];
    logic [3:0]       cls_mem_d [DEPTH];
    logic [2:0]       flags_q, flags_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [3:0]       in_class;
    logic [2:0]       in_flags;
    logic [7:0]       in_exp;
    logic [22:0]      in_frac;
    logic [CNT_W-1:0] count_base;

    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;

    assign in_ready   = !full;
    assign out_valid  = !empty;
    // Gated with out_valid so the head fields read zero whenever nothing is queued.
    assign out_result = out_valid ? res_mem_q[rd_ptr_q] : '0;
    assign out_tag    = out_valid ? tag_mem_q[rd_ptr_q] : '0;
    assign out_class  = out_valid ? cls_mem_q[rd_ptr_q] : '0;
    assign flags      = flags_q;
    assign res_count  = count_q;

    assign in_exp  = in_result[30:23];
    assign in_frac = in_result[22:0];

    // Classify the incoming result; the adder flushes denormals, so exp==0 is zero.
    always_comb begin
        in_class = '0;
        if (in_exp == 8'hFF) begin
            if (in_frac != '0) begin
                in_class[CLS_NAN] = 1'b1;
            end else begin
                in_class[CLS_INF] = 1'b1;
            end
        end else if (in_exp == 8'h00) begin
            in_class[CLS_ZERO] = 1'b1;
        end else begin
            in_class[CLS_NORMAL] = 1'b1;
        end
        in_flags               = '0;
        in_flags[FLG_INVALID]  = in_class[CLS_NAN];
        in_flags[FLG_OVERFLOW] = in_class[CLS_INF];
        in_flags[FLG_ZERO]     = in_class[CLS_ZERO];
    end

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        res_mem_d = res_mem_q;
        tag_mem_d = tag_mem_q;
        cls_mem_d = cls_mem_q;
        if (push) begin
            res_mem_d[wr_ptr_q] = in_result;
            tag_mem_d[wr_ptr_q] = in_tag;
            cls_mem_d[wr_ptr_q] = in_class;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Sticky flags and retired count; a same-cycle push or pop survives a clear.
    always_comb begin
        flags_d = flags_clr ? 3'b000 : flags_q;
        if (push) begin
            flags_d = flags_d | in_flags;
        end
        count_base = flags_clr ? '0 : count_q;
        count_d    = count_base;
        if (pop && (count_base != '1)) begin
            count_d = count_base + CNT_ONE;
        end
    end

    // State registers; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            flags_q  <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
                cls_mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            flags_q   <= flags_d;
            count_q   <= count_d;
            res_mem_q <= res_mem_d;
            tag_mem_q <= tag_mem_d;
            cls_mem_q <= cls_mem_d;
        end
    end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Testbench for fpu_result_queue: directed sequences, a classification table,
// and a randomized run against a queue-based reference model. A second
// instance with a 3-bit counter exposes counter saturation.

module tb_fpu_result_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_class;
    logic [2:0]       flags;
    logic             flags_clr;
    logic [15:0]      res_count;

    logic             s_in_ready;
    logic             s_out_valid;
    logic [31:0]      s_out_result;
    logic [TAG_W-1:0] s_out_tag;
    logic [3:0]       s_out_class;
    logic [2:0]       s_flags;
    logic [2:0]       s_res_count;

    int checks;
    int failures;

    fpu_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_class(out_class), .flags(flags), .flags_clr(flags_clr),
        .res_count(res_count)
    );

    fpu_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_tag(in_tag), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_result(s_out_result), .out_tag(s_out_tag),
        .out_class(s_out_class), .flags(s_flags), .flags_clr(flags_clr),
        .res_count(s_res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  cls;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } entry_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec rule for classification, written directly from the IEEE fields.
    function automatic logic [3:0] cls_of(input logic [31:0] v);
        if (v[30:23] == 8'hFF) return (v[22:0] != 23'd0) ? 4'b1000 : 4'b0100;
        if (v[30:23] == 8'h00) return 4'b0010;
        return 4'b0001;
    endfunction

    function automatic logic [2:0] flg_of(input logic [31:0] v);
        logic [3:0] c;
        c = cls_of(v);
        return {c[1], c[2], c[3]};
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v[30:23] = 8'hFF;
            1: v[30:23] = 8'h00;
            2: v[22:0]  = 23'd0;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) v[22:0] = 23'd0;
        return v;
    endfunction

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flags_clr = 1'b0;
    endtask

    vec_t   vecs[10];
    entry_t q[$];
    logic [2:0]  flags_m;
    int          cnt_m;
    int          cnt_s_m;
    logic        push_m;
    logic        pop_m;
    logic        hold;

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{32'h3FC00000, 4'b0001, 3'b000};
        vecs[1] = '{32'h7F800000, 4'b0100, 3'b010};
        vecs[2] = '{32'hFF800000, 4'b0100, 3'b010};
        vecs[3] = '{32'h7FC00000, 4'b1000, 3'b001};
        vecs[4] = '{32'h7F800001, 4'b1000, 3'b001};
        vecs[5] = '{32'hFFFFFFFF, 4'b1000, 3'b001};
        vecs[6] = '{32'h00000000, 4'b0010, 3'b100};
        vecs[7] = '{32'h80000000, 4'b0010, 3'b100};
        vecs[8] = '{32'h007FFFFF, 4'b0010, 3'b100};
        vecs[9] = '{32'h00800000, 4'b0001, 3'b000};

        rst_n = 1'b0;
        in_result = '0;
        in_tag = '0;
        idle();
        #12;
        rst_n = 1'b1;
        tick();

        // 1: reset state, single push/pop
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_flags", flags, 0);
        chk("rst_res_count", res_count, 0);
        in_valid = 1'b1; in_result = 32'h3FC00000; in_tag = 4'd3; out_ready = 1'b1;
        #1;
        chk("t1_no_bypass", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_class", out_class, 4'b0001);
        chk("t1_out_tag", out_tag, 3);
        chk("t1_out_result", out_result, 32'h3FC00000);
        tick();
        chk("t1_empty_after_pop", out_valid, 0);
        chk("t1_res_count", res_count, 1);

        // 2: fill, drop on full, drain in order
        idle(); flags_clr = 1'b1; tick(); flags_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_result = 32'h41000000 + i; in_tag = TAG_W'(i + 5);
            tick();
        end
        chk("t2_full_in_ready", in_ready, 0);
        in_result = 32'h40000000; in_tag = 4'hF;
        tick();
        in_valid = 1'b0;
        chk("t2_still_full", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("t2_no_ready_path", in_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_drain_valid", out_valid, 1);
            chk("t2_drain_result", out_result, 32'h41000000 + i);
            chk("t2_drain_tag", out_tag, i + 5);
            tick();
            if (i == 0) chk("t2_ready_after_pop", in_ready, 1);
        end
        chk("t2_empty", out_valid, 0);
        chk("t2_res_count", res_count, DEPTH);

        // 3: inf / nan / zero classes and flags
        idle(); flags_clr = 1'b1; tick(); flags_clr = 1'b0;
        in_valid = 1'b1; in_result = 32'h7F800000; tick();
        in_result = 32'h7FC00000; tick();
        in_valid = 1'b0;
        chk("t3_class_inf", out_class, 4'b0100);
        chk("t3_flags_011", flags, 3'b011);
        out_ready = 1'b1; tick();
        chk("t3_class_nan", out_class, 4'b1000);
        tick(); out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'h00000000; tick();
        in_valid = 1'b0;
        chk("t3_flags_111", flags, 3'b111);
        chk("t3_class_zero", out_class, 4'b0010);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // 4: clear with coincident push, then clear with coincident pop
        flags_clr = 1'b1; in_valid = 1'b1; in_result = 32'h7FC00001; tick();
        in_valid = 1'b0;
        chk("t4_set_wins", flags, 3'b001);
        out_ready = 1'b1; tick();
        chk("t4_clr_with_pop_count", res_count, 1);
        chk("t4_clr_flags", flags, 0);
        out_ready = 1'b0; tick();
        chk("t4_clr_count", res_count, 0);
        flags_clr = 1'b0;

        // classification table
        for (int i = 0; i < 10; i++) begin
            idle(); flags_clr = 1'b1; tick(); flags_clr = 1'b0;
            in_valid = 1'b1; in_result = vecs[i].res; in_tag = TAG_W'(i); tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_class", i), out_class, vecs[i].cls);
            chk($sformatf("vec%0d_flags", i), flags, vecs[i].flg);
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end

        // 5: streaming at occupancy 1 across pointer wrap
        idle();
        in_valid = 1'b1; in_result = 32'h3F000000; in_tag = 4'd0; tick();
        for (int j = 1; j <= 2 * DEPTH + 1; j++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_result = 32'h3F000000 + j; in_tag = TAG_W'(j);
            chk("t5_in_ready", in_ready, 1);
            chk("t5_out_valid", out_valid, 1);
            chk("t5_out_result", out_result, 32'h3F000000 + j - 1);
            tick();
        end
        in_valid = 1'b0;
        chk("t5_last", out_result, 32'h3F000000 + 2 * DEPTH + 1);
        tick();
        chk("t5_drained", out_valid, 0);
        out_ready = 1'b0;

        // 6: async reset with 3 entries queued
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_result = 32'h7F800000 + i; tick();
        end
        in_valid = 1'b0;
        chk("t6_pre_flags", flags, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_flags", flags, 0);
        chk("t6_res_count", res_count, 0);
        chk("t6_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_still_empty", out_valid, 0);

        // randomized run against the queue model
        q.delete();
        flags_m = '0; cnt_m = 0; cnt_s_m = 0; hold = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!hold) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_result = rand_val();
                in_tag    = TAG_W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flags_clr = ($urandom_range(0, 63) == 0);
            #1;
            chk("rnd_out_valid", out_valid, q.size() > 0);
            chk("rnd_in_ready", in_ready, q.size() < DEPTH);
            if (q.size() > 0) begin
                chk("rnd_out_result", out_result, q[0].res);
                chk("rnd_out_tag", out_tag, q[0].tag);
                chk("rnd_out_class", out_class, cls_of(q[0].res));
            end
            chk("rnd_flags", flags, flags_m);
            chk("rnd_res_count", res_count, cnt_m);
            chk("rnd_res_count_sat", s_res_count, cnt_s_m);
            push_m = in_valid && (q.size() < DEPTH);
            pop_m  = (q.size() > 0) && out_ready;
            hold   = in_valid && !push_m;
            if (flags_clr) begin
                flags_m = '0; cnt_m = 0; cnt_s_m = 0;
            end
            if (pop_m) begin
                void'(q.pop_front());
                if (cnt_m < 65535) cnt_m++;
                if (cnt_s_m < 7) cnt_s_m++;
            end
            if (push_m) begin
                q.push_back('{in_result, in_tag});
                flags_m = flags_m | flg_of(in_result);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
